// File: rtl/source_gen_pkg.sv
// Shared constants for the FMC test-pattern source selector.
// Two-state controller: RUN streams the selected channel, BLANK drives the idle word.
`timescale 1ns/1ps
package source_gen_pkg;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] BLANK = 1'b1;

  localparam logic [15:0] IDLE_DEFAULT = 16'h0000;

endpackage

// File: rtl/source_gen_sel_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and
// a one-cycle pulse on each debounced press (released -> pressed).
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DEB_CYC = 16
) (
  input  logic clk1280,
  input  logic rst_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEB_CYC);

  logic          sync1_q, sync2_q;
  logic          deb_q, deb_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The counter tracks how long the synced level has disagreed with the
  // debounced level; any agreeing sample starts the count over.
  always_comb begin
    deb_d   = deb_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == CW'(DEB_CYC - 1)) begin
        deb_d   = sync2_q;
        press_d = deb_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/source_gen_sel.sv
// N-channel test-pattern selector for the FMC output bus; every channel
// change is bracketed by a fixed run of idle words.
`timescale 1ns/1ps
module source_gen_sel
  import source_gen_pkg::*;
#(
  parameter int              NCH       = 4,
  parameter int              DW        = 16,
  parameter int              DEB_CYC   = 16,
  parameter int              GAP_CYC   = 8,
  parameter logic [DW-1:0]   IDLE_WORD = DW'(IDLE_DEFAULT),
  localparam int             SELW      = $clog2(NCH)
) (
  input  logic              clk1280,
  input  logic              rst_n,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              btn_next_n,
  input  logic [SELW-1:0]   sel_ext,
  input  logic              sel_load,
  output logic [DW-1:0]     source_out,
  output logic [SELW-1:0]   indic,
  output logic              switching
);

  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  logic            press;
  logic [0:0]      state_q, state_d;
  logic [SELW-1:0] indic_q, indic_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic            sw_q, sw_d;
  logic [DW-1:0]   out_q, out_d;
  logic [SELW-1:0] next_idx;
  logic            load_ok;

  btn_debounce #(
    .DEB_CYC(DEB_CYC)
  ) u_deb (
    .clk1280    (clk1280),
    .rst_n      (rst_n),
    .btn_n      (btn_next_n),
    .press_pulse(press)
  );

  assign next_idx = (indic_q == SELW'(NCH - 1)) ? '0 : indic_q + SELW'(1);
  assign load_ok  = sel_load && (int'(sel_ext) < NCH) && (sel_ext != indic_q);

  // A direct load always beats a button press; presses are dropped while blanking.
  always_comb begin
    state_d = state_q;
    indic_d = indic_q;
    gap_d   = gap_q;
    sw_d    = sw_q;
    out_d   = out_q;
    if (state_q == RUN) begin
      out_d = ch_data[int'(indic_q)*DW +: DW];
      if (load_ok || press) begin
        indic_d = load_ok ? sel_ext : next_idx;
        gap_d   = GW'(GAP_CYC - 1);
        sw_d    = 1'b1;
        state_d = BLANK;
      end
    end else begin
      out_d = IDLE_WORD;
      if (load_ok) begin
        indic_d = sel_ext;
        gap_d   = GW'(GAP_CYC - 1);
      end else if (gap_q == '0) begin
        sw_d    = 1'b0;
        state_d = RUN;
      end else begin
        gap_d = gap_q - GW'(1);
      end
    end
  end

  always_ff @(posedge clk1280 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      indic_q <= '0;
      gap_q   <= '0;
      sw_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      indic_q <= indic_d;
      gap_q   <= gap_d;
      sw_q    <= sw_d;
      out_q   <= out_d;
    end
  end

  assign source_out = out_q;
  assign indic      = indic_q;
  assign switching  = sw_q;

endmodule

// File: tb/tb_source_gen_sel.sv
// Self-checking bench for source_gen_sel: directed load table, button and
// blanking corner cases, then randomized loads against a behavioural model.
`timescale 1ns/1ps
module tb_source_gen_sel;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int GAP = 8;
  localparam int DEB = 16;

  logic              clk1280 = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] chData;
  logic              btnNextN;
  logic [1:0]        selExt;
  logic              selLoad;
  logic [DW-1:0]     sourceOut;
  logic [1:0]        indic;
  logic              switching;

  logic [3*DW-1:0]   chData3;
  logic              btnNextN3;
  logic [1:0]        selExt3;
  logic              selLoad3;
  logic [DW-1:0]     sourceOut3;
  logic [1:0]        indic3;
  logic              switching3;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 clk1280 = ~clk1280;

  source_gen_sel #(.NCH(NCH), .DW(DW), .DEB_CYC(DEB), .GAP_CYC(GAP)) dut (
    .clk1280   (clk1280),
    .rst_n     (rst_n),
    .ch_data   (chData),
    .btn_next_n(btnNextN),
    .sel_ext   (selExt),
    .sel_load  (selLoad),
    .source_out(sourceOut),
    .indic     (indic),
    .switching (switching)
  );

  source_gen_sel #(.NCH(3), .DW(DW), .DEB_CYC(DEB), .GAP_CYC(GAP)) dut3 (
    .clk1280   (clk1280),
    .rst_n     (rst_n),
    .ch_data   (chData3),
    .btn_next_n(btnNextN3),
    .sel_ext   (selExt3),
    .sel_load  (selLoad3),
    .source_out(sourceOut3),
    .indic     (indic3),
    .switching (switching3)
  );

  typedef struct {
    logic [1:0]  ext;
    logic [1:0]  expIndic;
    logic        expSw;
    logic [15:0] expWord;
  } loadVec_t;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    totalCnt++;
    if (actual === expected) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk1280);
    #1;
  endtask

  task automatic applyStimulus(input logic load, input logic [1:0] ext);
    selLoad = load;
    selExt  = ext;
  endtask

  task automatic waitSwitch(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (switching) begin
        seen = 1'b1;
        return;
      end
      step(1);
    end
  endtask

  // Called right after the edge where switching rose (or the gap restarted).
  task automatic checkGap(input string tag, input logic [15:0] newWord);
    int idleCnt = 0;
    int swHigh  = 0;
    for (int i = 1; i <= GAP; i++) begin
      step(1);
      if (sourceOut === 16'h0000) idleCnt++;
      if (i < GAP && switching === 1'b1) swHigh++;
    end
    checkOutput({tag, "_idle_words"}, 32'(idleCnt), 32'(GAP));
    checkOutput({tag, "_sw_high"}, 32'(swHigh), 32'(GAP - 1));
    checkOutput({tag, "_sw_fall"}, 32'(switching), 32'd0);
    step(1);
    checkOutput({tag, "_new_word"}, 32'(sourceOut), 32'(newWord));
  endtask

  task automatic loadAndSettle(input logic [1:0] ext);
    applyStimulus(1'b1, ext);
    step(1);
    applyStimulus(1'b0, 2'd0);
    step(GAP + 2);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    loadVec_t vecs[5];
    bit seen;
    int rises;
    logic prevSw;
    int mIndic;
    int idleLeft;
    logic [15:0] expOut;

    vecs[0] = '{ext: 2'd2, expIndic: 2'd2, expSw: 1'b1, expWord: 16'h3333};
    vecs[1] = '{ext: 2'd2, expIndic: 2'd2, expSw: 1'b0, expWord: 16'h3333};
    vecs[2] = '{ext: 2'd0, expIndic: 2'd0, expSw: 1'b1, expWord: 16'h1111};
    vecs[3] = '{ext: 2'd3, expIndic: 2'd3, expSw: 1'b1, expWord: 16'h4444};
    vecs[4] = '{ext: 2'd1, expIndic: 2'd1, expSw: 1'b1, expWord: 16'h2222};

    rst_n     = 1'b0;
    btnNextN  = 1'b1;
    btnNextN3 = 1'b1;
    selLoad3  = 1'b0;
    selExt3   = 2'd0;
    applyStimulus(1'b0, 2'd0);
    for (int k = 0; k < NCH; k++) chData[k*DW +: DW] = 16'(16'h1111 * (k + 1));
    for (int k = 0; k < 3; k++) chData3[k*DW +: DW] = 16'(16'h1111 * (k + 1));

    // Reset values, then first channel word after release
    step(2);
    checkOutput("rst_out", 32'(sourceOut), 32'd0);
    checkOutput("rst_indic", 32'(indic), 32'd0);
    checkOutput("rst_sw", 32'(switching), 32'd0);
    rst_n = 1'b1;
    step(2);
    checkOutput("post_rst_out", 32'(sourceOut), 32'h1111);
    checkOutput("post_rst_indic", 32'(indic), 32'd0);

    // Directed sel_load table
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, vecs[i].ext);
      step(1);
      applyStimulus(1'b0, 2'd0);
      checkOutput($sformatf("tbl%0d_indic", i), 32'(indic), 32'(vecs[i].expIndic));
      checkOutput($sformatf("tbl%0d_sw", i), 32'(switching), 32'(vecs[i].expSw));
      step(GAP + 2);
      checkOutput($sformatf("tbl%0d_word", i), 32'(sourceOut), 32'(vecs[i].expWord));
    end

    // Clean press: 1 -> 2
    btnNextN = 1'b0;
    waitSwitch(40, seen);
    checkOutput("press_seen", 32'(seen), 32'd1);
    checkOutput("press_indic", 32'(indic), 32'd2);
    checkGap("press", 16'h3333);
    btnNextN = 1'b1;
    step(30);
    checkOutput("release_indic", 32'(indic), 32'd2);

    // Bouncing button: exactly one press after it settles low
    rises  = 0;
    prevSw = switching;
    for (int i = 0; i < 40; i++) begin
      btnNextN = ((i / 3) % 2) == 0;
      step(1);
      if (switching && !prevSw) rises++;
      prevSw = switching;
    end
    btnNextN = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step(1);
      if (switching && !prevSw) rises++;
      prevSw = switching;
    end
    btnNextN = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (switching && !prevSw) rises++;
      prevSw = switching;
    end
    checkOutput("bounce_presses", 32'(rises), 32'd1);
    checkOutput("bounce_indic", 32'(indic), 32'd3);

    // Wrap 3 -> 0
    btnNextN = 1'b0;
    waitSwitch(40, seen);
    checkOutput("wrap_seen", 32'(seen), 32'd1);
    checkOutput("wrap_indic", 32'(indic), 32'd0);
    checkGap("wrap", 16'h1111);
    btnNextN = 1'b1;
    step(30);

    // NCH=3 instance: out-of-range load ignored, wrap 2 -> 0
    selLoad3 = 1'b1; selExt3 = 2'd2;
    step(1);
    selLoad3 = 1'b0;
    step(GAP + 2);
    checkOutput("nch3_load_indic", 32'(indic3), 32'd2);
    selLoad3 = 1'b1; selExt3 = 2'd3;
    step(1);
    selLoad3 = 1'b0;
    checkOutput("nch3_oob_sw", 32'(switching3), 32'd0);
    checkOutput("nch3_oob_indic", 32'(indic3), 32'd2);
    btnNextN3 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(1);
      if (switching3) seen = 1'b1;
    end
    checkOutput("nch3_wrap_seen", 32'(seen), 32'd1);
    checkOutput("nch3_wrap_indic", 32'(indic3), 32'd0);
    step(GAP + 1);
    checkOutput("nch3_wrap_word", 32'(sourceOut3), 32'h1111);
    btnNextN3 = 1'b1;
    step(30);
    checkOutput("nch3_final_indic", 32'(indic3), 32'd0);

    // Load during BLANK restarts the gap toward the new target
    applyStimulus(1'b1, 2'd1);
    step(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("blank_first_indic", 32'(indic), 32'd1);
    step(2);
    applyStimulus(1'b1, 2'd2);
    step(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("blank_reload_indic", 32'(indic), 32'd2);
    checkOutput("blank_reload_sw", 32'(switching), 32'd1);
    checkGap("blank_reload", 16'h3333);

    // Press and load in the same cycle: load wins
    loadAndSettle(2'd0);
    btnNextN = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (dut.u_deb.press_pulse) seen = 1'b1;
      else step(1);
    end
    checkOutput("coincide_pulse_seen", 32'(seen), 32'd1);
    applyStimulus(1'b1, 2'd3);
    step(1);
    applyStimulus(1'b0, 2'd0);
    checkOutput("coincide_indic", 32'(indic), 32'd3);
    checkOutput("coincide_sw", 32'(switching), 32'd1);
    checkGap("coincide", 16'h4444);
    btnNextN = 1'b1;
    step(30);
    checkOutput("coincide_final_indic", 32'(indic), 32'd3);

    // Reset in the middle of a gap
    applyStimulus(1'b1, 2'd2);
    step(1);
    applyStimulus(1'b0, 2'd0);
    step(3);
    rst_n = 1'b0;
    #2;
    checkOutput("midrst_out", 32'(sourceOut), 32'd0);
    checkOutput("midrst_indic", 32'(indic), 32'd0);
    checkOutput("midrst_sw", 32'(switching), 32'd0);
    step(2);
    rst_n = 1'b1;
    step(2);
    checkOutput("midrst_release_sw", 32'(switching), 32'd0);
    checkOutput("midrst_release_out", 32'(sourceOut), 32'h1111);

    // Randomized loads and data against the behavioural model
    mIndic   = 0;
    idleLeft = 0;
    for (int n = 0; n < 400; n++) begin
      chData = {$urandom(), $urandom()};
      applyStimulus($urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
      expOut = (idleLeft > 0) ? 16'h0000 : chData[mIndic*DW +: DW];
      if (selLoad && int'(selExt) != mIndic) begin
        mIndic   = int'(selExt);
        idleLeft = GAP;
      end else if (idleLeft > 0) begin
        idleLeft--;
      end
      step(1);
      checkOutput($sformatf("rnd%0d_out", n), 32'(sourceOut), 32'(expOut));
      checkOutput($sformatf("rnd%0d_indic", n), 32'(indic), 32'(mIndic));
      checkOutput($sformatf("rnd%0d_sw", n), 32'(switching), 32'(idleLeft > 0));
    end
    applyStimulus(1'b0, 2'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
